// File: rtl/ap_vector_burst_mem.sv
// ap_vector_burst_mem
//   Row-organised vector store for the solver's AP/direction vectors. Each row
//   holds no_of_units lanes of element_width bits. A lane-masked write port
//   works in parallel with a burst read engine that streams consecutive rows
//   over a valid/ready handshake. Out-of-range writes or burst starts set a
//   sticky addr_error.
//
//   Ports
//     clk, rst         clock; asynchronous active-high reset
//     write_enable     write request this cycle
//     write_address    row to write
//     write_lane_mask  bit i = 1 writes lane i
//     input_data       write data, lane i at [EW*(i+1)-1 : EW*i]
//     burst_start      single-cycle burst request (honoured only when idle)
//     burst_address    first row of the burst
//     burst_length     number of rows to stream (0 allowed)
//     burst_stride     row step per fetch (only with AP_BURST_STRIDE_EN)
//     burst_busy       burst engine streaming
//     out_valid        out_data/out_address hold a row
//     out_ready        consumer accepts the row on out_valid && out_ready
//     out_data         streamed row
//     out_address      row index of out_data
//     burst_done       one-cycle pulse after the last row is accepted
//     addr_error       sticky out-of-range flag, cleared only by rst
//
//   Build option: define AP_BURST_STRIDE_EN to add burst_stride; otherwise
//   the burst pointer advances by one row with wrap to 0.
module ap_vector_burst_mem #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   write_enable,
  input  logic [address_width-1:0]               write_address,
  input  logic [no_of_units-1:0]                 write_lane_mask,
  input  logic [element_width*no_of_units-1:0]   input_data,
  input  logic                                   burst_start,
  input  logic [address_width-1:0]               burst_address,
  input  logic [address_width-1:0]               burst_length,
`ifdef AP_BURST_STRIDE_EN
  input  logic [address_width-1:0]               burst_stride,
`endif
  output logic                                   burst_busy,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [element_width*no_of_units-1:0]   out_data,
  output logic [address_width-1:0]              out_address,
  output logic                                   burst_done,
  output logic                                   addr_error
);

  localparam int W     = element_width * no_of_units;
  localparam int IDX_W = $clog2(memory_height);
  localparam logic [address_width-1:0] HEIGHT = address_width'(memory_height);
  localparam logic [address_width-1:0] LAST   = address_width'(memory_height - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [W-1:0]             r_mem [0:memory_height-1];
  logic [address_width-1:0] r_ptr;
  logic [address_width-1:0] r_remaining;
  logic                     r_out_valid;
  logic [W-1:0]             r_out_data;
  logic [address_width-1:0] r_out_address;
  logic                     r_addr_error;
`ifdef AP_BURST_STRIDE_EN
  logic [address_width-1:0] r_stride;
  logic [address_width:0]   w_ptr_sum;
  logic [address_width:0]   w_ptr_wrap;
`endif

  logic                     w_wr_ok;
  logic                     w_wr_err;
  logic                     w_burst_oob;
  logic                     w_load;
  logic                     w_fetch;
  logic                     w_start_err;
  logic [W-1:0]             w_rd_row;
  logic [W-1:0]             w_fetch_row;
  logic [address_width-1:0] w_ptr_nxt;

  assign w_wr_ok     = write_enable && (write_address < HEIGHT);
  assign w_wr_err    = write_enable && (write_address >= HEIGHT);
  assign w_burst_oob = burst_address >= HEIGHT;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int unsigned i = 0; i < no_of_units; i++) begin
        if (write_lane_mask[i])
          r_mem[write_address[IDX_W-1:0]][i*element_width +: element_width]
            <= input_data[i*element_width +: element_width];
      end
    end
  end

  // Write-first per lane when a write hits the row being fetched.
  always_comb begin
    w_rd_row    = r_mem[r_ptr[IDX_W-1:0]];
    w_fetch_row = w_rd_row;
    if (w_wr_ok && (write_address == r_ptr)) begin
      for (int unsigned i = 0; i < no_of_units; i++) begin
        if (write_lane_mask[i])
          w_fetch_row[i*element_width +: element_width]
            = input_data[i*element_width +: element_width];
      end
    end
  end

`ifdef AP_BURST_STRIDE_EN
  assign w_ptr_sum  = {1'b0, r_ptr} + {1'b0, r_stride};
  assign w_ptr_wrap = w_ptr_sum - {1'b0, HEIGHT};
  assign w_ptr_nxt  = (w_ptr_sum >= {1'b0, HEIGHT}) ? w_ptr_wrap[address_width-1:0]
                                                     : w_ptr_sum[address_width-1:0];
`else
  assign w_ptr_nxt  = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fetch     = 1'b0;
    w_start_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (burst_start) begin
          if (w_burst_oob) begin
            w_start_err = 1'b1;
          end else if (burst_length == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        w_fetch = (r_remaining != '0) && (!r_out_valid || out_ready);
        if ((r_remaining == '0) && r_out_valid && out_ready)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_remaining   <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_address <= '0;
      r_addr_error  <= 1'b0;
`ifdef AP_BURST_STRIDE_EN
      r_stride      <= '0;
`endif
    end else begin
      if (w_wr_err || w_start_err)
        r_addr_error <= 1'b1;
      if (w_load) begin
        r_ptr       <= burst_address;
        r_remaining <= burst_length;
`ifdef AP_BURST_STRIDE_EN
        r_stride    <= burst_stride;
`endif
      end
      if (w_fetch) begin
        r_out_data    <= w_fetch_row;
        r_out_address <= r_ptr;
        r_out_valid   <= 1'b1;
        r_ptr         <= w_ptr_nxt;
        r_remaining   <= r_remaining - 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign burst_busy  = (r_state == S_STREAM);
  assign burst_done  = (r_state == S_DONE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_address = r_out_address;
  assign addr_error  = r_addr_error;

endmodule

// File: tb/tb_ap_vector_burst_mem.sv
module tb_ap_vector_burst_mem;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int MH = 1000;
  localparam int AW = 11;
  localparam int W  = EW * NU;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_enable = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [NU-1:0] write_lane_mask = '0;
  logic [W-1:0]  input_data = '0;
  logic          burst_start = 1'b0;
  logic [AW-1:0] burst_address = '0;
  logic [AW-1:0] burst_length = '0;
`ifdef AP_BURST_STRIDE_EN
  logic [AW-1:0] burst_stride = 11'd1;
`endif
  logic          burst_busy;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_address;
  logic          burst_done;
  logic          addr_error;

  ap_vector_burst_mem #(
    .element_width(EW),
    .no_of_units  (NU),
    .memory_height(MH),
    .address_width(AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_lane_mask(write_lane_mask),
    .input_data     (input_data),
    .burst_start    (burst_start),
    .burst_address  (burst_address),
    .burst_length   (burst_length),
`ifdef AP_BURST_STRIDE_EN
    .burst_stride   (burst_stride),
`endif
    .burst_busy     (burst_busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_address    (out_address),
    .burst_done     (burst_done),
    .addr_error     (addr_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  exp_t          sb[$];
  logic [W-1:0]  model [0:MH-1];
  int            errors = 0;
  int            checks = 0;
  int            accepted = 0;
  int            done_pulses = 0;
  logic [W-1:0]  last_data;
  logic [AW-1:0] last_addr;
  logic          hold_pending = 1'b0;
  logic [W-1:0]  held_data;
  logic [AW-1:0] held_addr;

  // Monitor: scoreboard pops on every handshake, hold check under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_address !== held_addr) begin
          errors++;
          $display("FAIL hold: valid=%b addr=%0d required valid=1 addr=%0d data unchanged",
                   out_valid, out_address, held_addr);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row: addr=%0d required no row", out_address);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_address !== e.addr || out_data !== e.data) begin
            errors++;
            $display("FAIL stream_row: addr=%0d data=%h required addr=%0d data=%h",
                     out_address, out_data, e.addr, e.data);
          end
        end
        accepted++;
        last_data = out_data;
        last_addr = out_address;
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      held_addr    = out_address;
      if (burst_done) done_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [NU-1:0] m);
    write_enable    = 1'b1;
    write_address   = a;
    write_lane_mask = m;
    input_data      = d;
    if (int'(a) < MH)
      for (int i = 0; i < NU; i++)
        if (m[i]) model[int'(a)][i*EW +: EW] = d[i*EW +: EW];
    tick();
    write_enable = 1'b0;
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [AW-1:0] len,
                             input int stride, input bit push);
    int p;
    burst_start   = 1'b1;
    burst_address = a;
    burst_length  = len;
`ifdef AP_BURST_STRIDE_EN
    burst_stride  = AW'(stride);
`endif
    if (push) begin
      p = int'(a);
      for (int k = 0; k < int'(len); k++) begin
        sb.push_back({AW'(p), model[p]});
        p = p + stride;
        if (p >= MH) p = p - MH;
      end
    end
    tick();
    burst_start = 1'b0;
  endtask

  task automatic drain(input int done_before, input int acc_before, input int rows, input string name);
    for (int c = 0; c < 200; c++) begin
      if (done_pulses > done_before && sb.size() == 0) break;
      tick();
    end
    checks++;
    if (done_pulses != done_before + 1 || sb.size() != 0 || accepted - acc_before != rows) begin
      errors++;
      $display("FAIL %s_end: done_pulses=%0d rows=%0d pending=%0d required done_pulses=%0d rows=%0d pending=0",
               name, done_pulses - done_before, accepted - acc_before, sb.size(), 1, rows);
    end
  endtask

  task automatic test_reset();
    #2;
    checks += 6;
    if (burst_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", burst_busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: %b required 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rst_data: %h required 0", out_data); end
    if (out_address !== '0) begin errors++; $display("FAIL rst_addr: %0d required 0", out_address); end
    if (burst_done !== 1'b0) begin errors++; $display("FAIL rst_done: %b required 0", burst_done); end
    if (addr_error !== 1'b0) begin errors++; $display("FAIL rst_err: %b required 0", addr_error); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_masked_write();
    logic [W-1:0] d, exp;
    int db, ab;
    for (int i = 0; i < NU; i++) d[i*EW +: EW] = 32'h11111111 * (i + 1);
    write_row(11'd5, d, 8'hFF);
    for (int i = 0; i < NU; i++) d[i*EW +: EW] = 32'hAAAAAAAA;
    write_row(11'd5, d, 8'h0F);
    for (int i = 0; i < NU; i++) exp[i*EW +: EW] = (i < 4) ? 32'hAAAAAAAA : 32'h11111111 * (i + 1);
    db = done_pulses; ab = accepted;
    start_burst(11'd5, 11'd1, 1, 1'b1);
    drain(db, ab, 1, "masked");
    checks++;
    if (last_data !== exp || last_addr !== 11'd5) begin
      errors++;
      $display("FAIL masked_data: addr=%0d data=%h required addr=5 data=%h", last_addr, last_data, exp);
    end
  endtask

  task automatic test_streaming();
    int db, ab;
    for (int n = 10; n < 14; n++) write_row(AW'(n), W'(n), 8'hFF);
    db = done_pulses; ab = accepted;
    start_burst(11'd10, 11'd4, 1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || burst_busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_latency1: valid=%b busy=%b required valid=0 busy=1", out_valid, burst_busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_address !== 11'd10) begin
      errors++;
      $display("FAIL stream_first: valid=%b addr=%0d required valid=1 addr=10", out_valid, out_address);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_address !== AW'(10 + k)) begin
        errors++;
        $display("FAIL stream_seq: valid=%b addr=%0d required valid=1 addr=%0d", out_valid, out_address, 10 + k);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || burst_done !== 1'b1 || burst_busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_done: valid=%b done=%b busy=%b required 0 1 0", out_valid, burst_done, burst_busy);
    end
    tick();
    checks++;
    if (burst_done !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_width: done=%b required 0", burst_done);
    end
    drain(db, ab, 4, "stream");
  endtask

  task automatic test_backpressure_wrap();
    logic [3:0] pat = 4'b1001;
    int db, ab;
    write_row(11'd998, {8{32'h0998_0998}}, 8'hFF);
    write_row(11'd999, {8{32'h0999_0999}}, 8'hFF);
    write_row(11'd0,   {8{32'h0000_F000}}, 8'hFF);
    write_row(11'd1,   {8{32'h0001_F001}}, 8'hFF);
    db = done_pulses; ab = accepted;
    start_burst(11'd998, 11'd4, 1, 1'b1);
    for (int c = 0; c < 60; c++) begin
      if (done_pulses > db) break;
      out_ready = pat[c % 4];
      tick();
    end
    out_ready = 1'b1;
    drain(db, ab, 4, "backpressure");
  endtask

  task automatic test_boundaries();
    int db, ab;
    db = done_pulses; ab = accepted;
    start_burst(11'd3, 11'd0, 1, 1'b0);
    checks++;
    if (burst_done !== 1'b1 || burst_busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: done=%b busy=%b valid=%b required 1 0 0", burst_done, burst_busy, out_valid);
    end
    tick();
    checks++;
    if (burst_done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL len0_after: done=%b valid=%b required 0 0", burst_done, out_valid);
    end
    drain(db, ab, 0, "len0");

    checks++;
    if (addr_error !== 1'b0) begin errors++; $display("FAIL err_clean: %b required 0", addr_error); end
    write_row(11'd1000, {8{32'hDEADBEEF}}, 8'hFF);
    checks++;
    if (addr_error !== 1'b1) begin errors++; $display("FAIL wr_oob_err: %b required 1", addr_error); end
    db = done_pulses; ab = accepted;
    start_burst(11'd998, 11'd3, 1, 1'b1);
    drain(db, ab, 3, "wr_oob_unchanged");

    db = done_pulses; ab = accepted;
    start_burst(11'd10, 11'd4, 1, 1'b1);
    tick();
    burst_start   = 1'b1;
    burst_address = 11'd500;
    burst_length  = 11'd2;
    tick();
    burst_start = 1'b0;
    drain(db, ab, 4, "start_ignored");
  endtask

  task automatic test_rdw();
    logic [W-1:0] d, exp;
    int db, ab;
    for (int i = 0; i < NU; i++) d[i*EW +: EW] = 32'hC0DE0000 + i;
    write_row(11'd40, d, 8'hFF);
    for (int i = 0; i < NU; i++) exp[i*EW +: EW] = (i < 4) ? 32'h12345678 : 32'hC0DE0000 + i;
    sb.push_back({11'd40, exp});
    db = done_pulses; ab = accepted;
    start_burst(11'd40, 11'd1, 1, 1'b0);
    write_row(11'd40, {8{32'h12345678}}, 8'h0F);
    drain(db, ab, 1, "rdw");
  endtask

  task automatic test_reset_mid_burst();
    int db, ab;
    for (int n = 20; n < 26; n++) write_row(AW'(n), {8{32'hA000_0000 + n}}, 8'hFF);
    db = done_pulses; ab = accepted;
    start_burst(11'd20, 11'd6, 1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (accepted - ab >= 2) break;
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (accepted - ab != 2 || out_valid !== 1'b0 || burst_busy !== 1'b0 || addr_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: rows=%0d valid=%b busy=%b err=%b required rows=2 valid=0 busy=0 err=0",
               accepted - ab, out_valid, burst_busy, addr_error);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (done_pulses != db || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_nodone: done_pulses=%0d valid=%b required 0 0", done_pulses - db, out_valid);
    end
    start_burst(11'd1000, 11'd2, 1, 1'b0);
    checks++;
    if (addr_error !== 1'b1 || burst_busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_oob: err=%b busy=%b required 1 0", addr_error, burst_busy);
    end
    db = done_pulses; ab = accepted;
    start_burst(11'd20, 11'd3, 1, 1'b1);
    drain(db, ab, 3, "after_rst");
  endtask

`ifdef AP_BURST_STRIDE_EN
  task automatic test_stride();
    int db, ab;
    write_row(11'd990, {8{32'h0990_0990}}, 8'hFF);
    write_row(11'd998, {8{32'h0998_5555}}, 8'hFF);
    write_row(11'd6,   {8{32'h0006_0006}}, 8'hFF);
    db = done_pulses; ab = accepted;
    start_burst(11'd990, 11'd3, 8, 1'b1);
    drain(db, ab, 3, "stride");
    checks++;
    if (last_addr !== 11'd6) begin
      errors++;
      $display("FAIL stride_last: addr=%0d required 6", last_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_masked_write();
    test_streaming();
    test_backpressure_wrap();
    test_boundaries();
    test_rdw();
    test_reset_mid_burst();
`ifdef AP_BURST_STRIDE_EN
    test_stride();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ap_vector_burst_mem.md
Name: ap_vector_burst_mem

Overview:
- Next-generation vector store for the AP/direction vectors of the iterative solver datapath.
- Each row holds `no_of_units` lanes of `element_width` bits.
- Adds per-lane write masking, range checking, and a burst read engine that streams consecutive rows to the downstream dot-product/update units over a valid/ready handshake.
- Replaces the combinational single-address read with a registered, flow-controlled stream.

Parameters:
- element_width, 32, bits per lane element
- no_of_units, 8, lanes per row; row width W = element_width*no_of_units
- memory_height, 1000, number of rows (valid addresses 0..memory_height-1)
- address_width, $clog2(memory_height)+1, width of address and length fields

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- write_enable  input  1  write request this cycle
- write_address  input  address_width  row to write
- write_lane_mask  input  no_of_units  bit i=1 writes lane i
- input_data  input  W  write data; lane i = bits [element_width*(i+1)-1 : element_width*i]
- burst_start  input  1  single-cycle request to start a burst
- burst_address  input  address_width  first row of burst
- burst_length  input  address_width  rows to stream (0 allowed)
- burst_busy  output  1  burst engine active
- out_valid  output  1  out_data holds a row
- out_ready  input  1  consumer accepts row when out_valid&&out_ready
- out_data  output  W  streamed row
- out_address  output  address_width  row index of out_data
- burst_done  output  1  one-cycle pulse after the last row is accepted
- addr_error  output  1  sticky; set on any out-of-range write or burst start

Behaviour:
- Reset (async assert): burst_busy=0, out_valid=0, out_data=0, out_address=0, burst_done=0, addr_error=0, FSM=IDLE. Memory contents are not reset. Reset during a burst aborts it; no burst_done is issued.
- Write port:
  - On a clk edge with write_enable=1 and write_address<memory_height, lanes with mask=1 take input_data. Other lanes are unchanged.
  - If write_address>=memory_height, no write occurs and addr_error is set.
  - Writes are accepted in every FSM state.
- FSM states: IDLE, STREAM, DONE.
  - IDLE, burst_start=1:
    - burst_address>=memory_height: set addr_error, stay IDLE.
    - burst_length=0: go to DONE.
    - Otherwise: load ptr=burst_address, remaining=burst_length, burst_busy=1, go to STREAM.
  - STREAM: a fetch occurs when remaining>0 and (out_valid==0 or out_ready==1). On a fetch:
    - out_data<=mem[ptr] (registered read; 1-cycle latency from fetch to out_valid); out_address<=ptr; out_valid<=1.
    - ptr wraps: memory_height-1 -> 0. Otherwise ptr+1.
    - remaining decrements.
  - When out_valid&&out_ready and no fetch occurs, out_valid<=0.
  - Once remaining=0 and the last row is accepted, go to DONE.
  - DONE: burst_done=1 for exactly one cycle, burst_busy=0, go to IDLE.
  - burst_start while burst_busy=1 is ignored (no error).
- Throughput: with out_ready held at 1, one row per cycle. The first out_valid rises 2 cycles after the burst_start edge.
- out_data and out_address hold stable while out_valid=1 and out_ready=0.
- Read-during-write, same row, same edge: fetched out_data is write-first per lane. Masked-in lanes return new input_data; other lanes return old contents.
- addr_error clears only on rst.

Optional Feature:
- Macro AP_BURST_STRIDE_EN.
- Defined:
  - Adds input burst_stride [address_width-1:0], sampled with burst_start.
  - ptr advances by burst_stride, modulo memory_height (wrap = ptr+stride-memory_height when the sum is >=memory_height).
  - Stride 0 repeats the same row burst_length times.
  - Port is absent when undefined.
- Undefined: stride is fixed at 1.

Test Plan:
- Masked write: write row 5 with data lanes=0x11111111..0x88888888, mask=8'hFF; then write row 5 with mask=8'h0F, data all 0xAAAAAAAA; burst row 5 length 1 -> out_data lanes0-3=0xAAAAAAAA, lanes4-7 = original 0x55555555..0x88888888, out_address=5.
- Streaming: rows 10..13 hold 10..13 in lane 0; burst_start addr=10 len=4, out_ready=1 -> out_valid high 4 consecutive cycles starting 2 cycles after start, out_address 10,11,12,13, then burst_done pulse of exactly 1 cycle.
- Backpressure and wrap: burst addr=998 len=4, out_ready toggled 1,0,0,1,... -> out_address sequence 998,999,0,1, each row held stable while ready=0, no row lost or duplicated.
- Boundaries: burst_length=0 -> burst_done pulse, no out_valid. write_address=1000 -> memory unchanged, addr_error=1. burst_start during a burst -> ignored.
- Reset mid-burst: assert rst after 2 of 6 rows -> out_valid=0, burst_busy=0, no burst_done; a new burst afterward streams correctly.
- AP_BURST_STRIDE_EN: burst addr=990 len=3 stride=8 -> out_address 990,998,6.
